rom_arbiter: RTL



---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/rom_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg
//   Shared constants and types for the two-port ROM arbiter.
//   NUM_PORTS  : number of requesters sharing the ROM
//   PORT_FETCH : port id of the instruction-fetch requester
//   PORT_LOAD  : port id of the data-load requester
//   port_id_t  : tag type carried with an in-flight ROM read
package rom_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;

    typedef logic [0:0] port_id_t;

endpackage : rom_arb_pkg

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin arbiter. A lone requester always wins; on a tie the
//   port that did not win most recently is granted.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector (bit i = port i wants the resource)
//   grant[1:0] : one-hot grant, combinational from req and history
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Id of the port granted most recently. Resets to 1 so that the
    // first tie after reset goes to port 0.
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // History only moves when something is actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule : rr_arbiter2

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one synchronous ROM (1-cycle registered read, read_enable-gated
//   output register) between a fetch port (0) and a load port (1).
//   At most one ROM read is issued per cycle; the read is tagged with the
//   winning port and its data lands in that port's response register, which
//   holds until the requester takes it.
//
//   Handshakes: a request transfers on the rising edge where
//   req_valid[i] & req_ready[i]; a response transfers on the rising edge
//   where resp_valid[i] & resp_ready[i]. req_ready is combinational from the
//   current request/state; resp_ready without resp_valid has no effect.
//
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     req_valid[1:0]   : port i presents a read request
//     req_ready[1:0]   : port i request accepted this cycle
//     req_addr         : port i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     resp_valid[1:0]  : port i response register holds data
//     resp_ready[1:0]  : port i consumes its response this cycle
//     resp_data        : port i data at [i*DATA_WIDTH +: DATA_WIDTH]
//     rom_read_enable  : ROM read strobe
//     rom_address      : ROM word address (0 when idle)
//     rom_data_out     : ROM registered read data
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_PORTS-1:0]              req_valid,
    output logic [NUM_PORTS-1:0]              req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
    output logic [NUM_PORTS-1:0]              resp_valid,
    input  logic [NUM_PORTS-1:0]              resp_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   resp_data,
    output logic                              rom_read_enable,
    output logic [ADDR_WIDTH-1:0]             rom_address,
    input  logic [DATA_WIDTH-1:0]             rom_data_out
);

    logic                 pend_valid;
    port_id_t             pend_id;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;

    // A port may only have one read outstanding: either in the ROM stage or
    // parked in its response register. Eligibility looks at the current
    // resp_valid, so a port consuming its response this cycle is re-granted
    // no earlier than the next cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] && !resp_valid[i] &&
                          !(pend_valid && (pend_id == port_id_t'(i)));
        end
    end

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .grant (grant)
    );

    assign req_ready       = grant;
    assign rom_read_enable = |grant;

    always_comb begin
        rom_address = '0;
        if (grant[PORT_FETCH]) begin
            rom_address = req_addr[PORT_FETCH*ADDR_WIDTH +: ADDR_WIDTH];
        end else if (grant[PORT_LOAD]) begin
            rom_address = req_addr[PORT_LOAD*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // In-flight tag and per-port response registers. A read tagged for
    // port i can only exist when resp_valid[i] was clear at grant time, so
    // the fill and the consume of one port never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            pend_valid <= |grant;
            if (|grant) begin
                pend_id <= grant[PORT_LOAD];
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pend_valid && (pend_id == port_id_t'(i))) begin
                    resp_valid[i]                          <= 1'b1;
                    resp_data[i*DATA_WIDTH +: DATA_WIDTH]  <= rom_data_out;
                end else if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule : rom_arbiter
